// File: rtl/multitap_keypad.sv
// Matrix keypad scanner, debouncer and multi-tap letter composer.
// Committed characters leave over a valid/ready handshake.
module multitap_keypad #(
  parameter int NUM_ROWS        = 4,
  parameter int NUM_COLS        = 4,
  parameter int TAPS_PER_KEY    = 3,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int TAP_TIMEOUT     = 50,
  parameter int SCAN_CYCLES     = 2
) (
  input  logic                clk,
  input  logic                nRst,
  input  logic [NUM_ROWS-1:0] row,
  output logic [NUM_COLS-1:0] col,
  output logic [7:0]          out_char,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [7:0]          preview_char,
  output logic                error
);

  localparam int NUM_KEYS = NUM_ROWS * NUM_COLS;
  localparam int KW  = $clog2(NUM_KEYS);
  localparam int TW  = (TAPS_PER_KEY > 1) ? $clog2(TAPS_PER_KEY) : 1;
  localparam int TMW = $clog2(TAP_TIMEOUT + 1);
  localparam int DW  = $clog2(DEBOUNCE_CYCLES);
  localparam int SW  = (SCAN_CYCLES > 1) ? $clog2(SCAN_CYCLES) : 1;

  localparam logic [KW-1:0]  KEY_SUBMIT = KW'(NUM_KEYS - 1);
  localparam logic [KW-1:0]  KEY_CLEAR  = KW'(NUM_KEYS - 2);
  localparam logic [DW-1:0]  DEB_LAST   = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [SW-1:0]  SCAN_LAST  = SW'(SCAN_CYCLES - 1);
  localparam logic [TMW-1:0] TIMEOUT_V  = TMW'(TAP_TIMEOUT);

  typedef enum logic [1:0] {IDLE, COMPOSE, EMIT} state_t;

  // Number of letters on a key; zero for unused keys and for CLEAR/SUBMIT.
  function automatic int taps_for(input logic [KW-1:0] key);
    int n;
    n = 26 - int'(key) * TAPS_PER_KEY;
    if (key >= KEY_CLEAR) n = 0;
    else if (n > TAPS_PER_KEY) n = TAPS_PER_KEY;
    else if (n < 0) n = 0;
    else n = n;
    return n;
  endfunction

  function automatic logic [7:0] letter(input logic [KW-1:0] key, input logic [TW-1:0] tap);
    int v;
    v = 65 + int'(key) * TAPS_PER_KEY + int'(tap);
    return v[7:0];
  endfunction

  function automatic logic [KW-1:0] encode(input logic [NUM_COLS-1:0] c, input logic [NUM_ROWS-1:0] r);
    int ri;
    int ci;
    ri = 0;
    ci = 0;
    for (int i = NUM_ROWS - 1; i >= 0; i--) ri = r[i] ? i : ri;
    for (int j = NUM_COLS - 1; j >= 0; j--) ci = c[j] ? j : ci;
    return KW'(ri * NUM_COLS + ci);
  endfunction

  logic [NUM_COLS-1:0] col_r;
  logic [SW-1:0]       scan_cnt_r;
  logic [NUM_ROWS-1:0] prev_row_r;
  logic [NUM_COLS-1:0] prev_col_r;
  logic [DW-1:0]       stab_cnt_r;
  logic [DW-1:0]       rel_cnt_r;
  logic                locked_r;
  logic                evt_r;
  logic                evt_multi_r;
  logic [KW-1:0]       evt_key_r;

  logic row_any_s;
  logic row_multi_s;
  logic same_s;
  logic [KW-1:0] key_s;

  assign row_any_s   = |row;
  assign row_multi_s = (row & (row - NUM_ROWS'(1))) != NUM_ROWS'(0);
  assign same_s      = (row == prev_row_r) && (col_r == prev_col_r);
  assign key_s       = encode(col_r, row);
  assign col         = col_r;

  // Column scanner: rotate while the keypad is quiet, freeze on any row activity.
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      col_r      <= NUM_COLS'(1);
      scan_cnt_r <= SW'(0);
    end else if (row_any_s) begin
      col_r      <= col_r;
      scan_cnt_r <= scan_cnt_r;
    end else if (scan_cnt_r == SCAN_LAST) begin
      col_r      <= {col_r[NUM_COLS-2:0], col_r[NUM_COLS-1]};
      scan_cnt_r <= SW'(0);
    end else begin
      scan_cnt_r <= scan_cnt_r + SW'(1);
    end
  end

  // Debouncer: one event per press, re-armed only after a stable release.
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      prev_row_r  <= NUM_ROWS'(0);
      prev_col_r  <= NUM_COLS'(0);
      stab_cnt_r  <= DW'(0);
      rel_cnt_r   <= DW'(0);
      locked_r    <= 1'b0;
      evt_r       <= 1'b0;
      evt_multi_r <= 1'b0;
      evt_key_r   <= KW'(0);
    end else begin
      prev_row_r <= row;
      prev_col_r <= col_r;
      evt_r      <= 1'b0;
      if (!locked_r) begin
        rel_cnt_r <= DW'(0);
        if (row_any_s && same_s) begin
          if (stab_cnt_r == DEB_LAST) begin
            stab_cnt_r  <= DW'(0);
            locked_r    <= 1'b1;
            evt_r       <= 1'b1;
            evt_multi_r <= row_multi_s;
            evt_key_r   <= key_s;
          end else begin
            stab_cnt_r <= stab_cnt_r + DW'(1);
          end
        end else if (row_any_s) begin
          stab_cnt_r <= DW'(1);
        end else begin
          stab_cnt_r <= DW'(0);
        end
      end else begin
        stab_cnt_r <= DW'(0);
        if (row_any_s) begin
          rel_cnt_r <= DW'(0);
        end else if (rel_cnt_r == DEB_LAST) begin
          rel_cnt_r <= DW'(0);
          locked_r  <= 1'b0;
        end else begin
          rel_cnt_r <= rel_cnt_r + DW'(1);
        end
      end
    end
  end

  state_t         state_r, state_n;
  logic [KW-1:0]  key_r, key_n, pend_key_r, pend_key_n;
  logic [TW-1:0]  tap_r, tap_n;
  logic [TMW-1:0] timer_r, timer_n;
  logic           pend_valid_r, pend_valid_n;
  logic [7:0]     out_char_r, out_char_n, preview_r, preview_n;
  logic           out_valid_r, out_valid_n, error_r, error_n;
  logic           evt_ok_s;
  int             evt_taps_s;

  assign evt_ok_s   = evt_r && !evt_multi_r;
  assign evt_taps_s = taps_for(evt_key_r);

  // Composer next-state: tap cycling, commits, pending key hand-over, error pulses.
  always_comb begin
    state_n      = state_r;
    key_n        = key_r;
    tap_n        = tap_r;
    timer_n      = timer_r;
    pend_valid_n = pend_valid_r;
    pend_key_n   = pend_key_r;
    out_char_n   = out_char_r;
    out_valid_n  = out_valid_r;
    error_n      = evt_r && evt_multi_r;
    preview_n    = 8'h20;
    case (state_r)
      IDLE: begin
        if (evt_ok_s) begin
          if (evt_key_r == KEY_SUBMIT || evt_key_r == KEY_CLEAR) begin
            out_char_n   = (evt_key_r == KEY_SUBMIT) ? 8'h0D : 8'h08;
            out_valid_n  = 1'b1;
            pend_valid_n = 1'b0;
            state_n      = EMIT;
          end else if (evt_taps_s > 0) begin
            key_n   = evt_key_r;
            tap_n   = TW'(0);
            timer_n = TMW'(0);
            state_n = COMPOSE;
          end else begin
            error_n = 1'b1;
          end
        end else begin
          state_n = IDLE;
        end
      end
      COMPOSE: begin
        if (evt_ok_s) begin
          if (evt_key_r == key_r) begin
            tap_n   = (int'(tap_r) + 1 >= taps_for(key_r)) ? TW'(0) : tap_r + TW'(1);
            timer_n = TMW'(0);
          end else if (evt_key_r == KEY_CLEAR) begin
            state_n = IDLE;
          end else if (evt_key_r == KEY_SUBMIT || evt_taps_s > 0) begin
            out_char_n   = letter(key_r, tap_r);
            out_valid_n  = 1'b1;
            pend_valid_n = (evt_key_r != KEY_SUBMIT);
            pend_key_n   = evt_key_r;
            state_n      = EMIT;
          end else begin
            error_n = 1'b1;
          end
        end else if (evt_r) begin
          timer_n = timer_r;
        end else if (timer_r == TIMEOUT_V) begin
          out_char_n   = letter(key_r, tap_r);
          out_valid_n  = 1'b1;
          pend_valid_n = 1'b0;
          state_n      = EMIT;
        end else begin
          timer_n = timer_r + TMW'(1);
        end
      end
      EMIT: begin
        // Presses arriving while the consumer stalls are dropped, not queued.
        error_n = evt_r;
        if (out_valid_r && out_ready) begin
          out_valid_n = 1'b0;
          if (pend_valid_r) begin
            key_n        = pend_key_r;
            tap_n        = TW'(0);
            timer_n      = TMW'(0);
            pend_valid_n = 1'b0;
            state_n      = COMPOSE;
          end else begin
            state_n = IDLE;
          end
        end else begin
          state_n = EMIT;
        end
      end
      default: begin
        state_n     = IDLE;
        out_valid_n = 1'b0;
      end
    endcase
    case (state_n)
      COMPOSE: preview_n = letter(key_n, tap_n);
      EMIT:    preview_n = pend_valid_n ? letter(pend_key_n, TW'(0)) : 8'h20;
      default: preview_n = 8'h20;
    endcase
  end

  // Composer state and registered outputs.
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      state_r      <= IDLE;
      key_r        <= KW'(0);
      tap_r        <= TW'(0);
      timer_r      <= TMW'(0);
      pend_valid_r <= 1'b0;
      pend_key_r   <= KW'(0);
      out_char_r   <= 8'h00;
      out_valid_r  <= 1'b0;
      preview_r    <= 8'h20;
      error_r      <= 1'b0;
    end else begin
      state_r      <= state_n;
      key_r        <= key_n;
      tap_r        <= tap_n;
      timer_r      <= timer_n;
      pend_valid_r <= pend_valid_n;
      pend_key_r   <= pend_key_n;
      out_char_r   <= out_char_n;
      out_valid_r  <= out_valid_n;
      preview_r    <= preview_n;
      error_r      <= error_n;
    end
  end

  assign out_char     = out_char_r;
  assign out_valid    = out_valid_r;
  assign preview_char = preview_r;
  assign error        = error_r;

endmodule

// File: tb/tb_multitap_keypad.sv
// Directed bench for multitap_keypad with a behavioural keypad matrix model.
module tb_multitap_keypad;

  logic       clk = 1'b0;
  logic       nRst = 1'b0;
  logic [3:0] row;
  logic [3:0] col;
  logic [7:0] out_char;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] preview_char;
  logic       error;

  logic       pressed = 1'b0;
  int         pcol = 0;
  logic [3:0] pmask = 4'b0000;

  int checks = 0;
  int errors = 0;
  int err_seen = 0;
  int unstable = 0;
  logic       last_valid = 1'b0;
  logic       last_ready = 1'b0;
  logic [7:0] last_char = 8'h00;

  multitap_keypad dut (
    .clk(clk), .nRst(nRst), .row(row), .col(col),
    .out_char(out_char), .out_valid(out_valid), .out_ready(out_ready),
    .preview_char(preview_char), .error(error)
  );

  always #5 clk = ~clk;

  // A held key connects its row(s) to the column currently being driven.
  assign row = (pressed && col[pcol]) ? pmask : 4'b0000;

  task automatic cyc();
    @(posedge clk);
    #1;
    if (error === 1'b1) err_seen++;
    if (last_valid && out_valid && !last_ready && out_char !== last_char) unstable++;
    last_valid = out_valid;
    last_ready = out_ready;
    last_char  = out_char;
  endtask

  task automatic press_raw(input int c, input logic [3:0] mask);
    pcol = c;
    pmask = mask;
    pressed = 1'b1;
    repeat (20) cyc();
    pressed = 1'b0;
    repeat (10) cyc();
  endtask

  task automatic tap(input int k);
    logic [3:0] m;
    m = 4'b0001 << (k / 4);
    press_raw(k % 4, m);
  endtask

  task automatic wait_valid();
    for (int i = 0; i < 200 && out_valid !== 1'b1; i++) cyc();
    checks++;
    if (out_valid !== 1'b1) begin errors++; $display("FAIL wait_valid: out_valid=%b required 1 within 200 cycles", out_valid); end
  endtask

  task automatic accept();
    out_ready = 1'b1;
    cyc();
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL accept_drop: out_valid=%b required 0", out_valid); end
  endtask

  task automatic test_reset();
    nRst = 1'b0;
    repeat (3) cyc();
    checks++; if (col !== 4'b0001) begin errors++; $display("FAIL reset_col: got %b required 0001", col); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b required 0", out_valid); end
    checks++; if (out_char !== 8'h00) begin errors++; $display("FAIL reset_char: got %h required 00", out_char); end
    checks++; if (preview_char !== 8'h20) begin errors++; $display("FAIL reset_preview: got %h required 20", preview_char); end
    checks++; if (error !== 1'b0) begin errors++; $display("FAIL reset_error: got %b required 0", error); end
    nRst = 1'b1;
    repeat (3) cyc();
  endtask

  task automatic test_multitap();
    tap(1);
    checks++; if (preview_char !== 8'h44) begin errors++; $display("FAIL multitap_prev1: got %h required 44", preview_char); end
    tap(1);
    checks++; if (preview_char !== 8'h45) begin errors++; $display("FAIL multitap_prev2: got %h required 45", preview_char); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL multitap_early: out_valid=%b required 0", out_valid); end
    wait_valid();
    checks++; if (out_char !== 8'h45) begin errors++; $display("FAIL multitap_char: got %h required 45", out_char); end
    checks++; if (preview_char !== 8'h20) begin errors++; $display("FAIL multitap_emit_prev: got %h required 20", preview_char); end
    accept();
    checks++; if (preview_char !== 8'h20) begin errors++; $display("FAIL multitap_idle_prev: got %h required 20", preview_char); end
  endtask

  task automatic test_wrap();
    tap(8);
    checks++; if (preview_char !== 8'h59) begin errors++; $display("FAIL wrap_prev1: got %h required 59", preview_char); end
    tap(8);
    checks++; if (preview_char !== 8'h5A) begin errors++; $display("FAIL wrap_prev2: got %h required 5A", preview_char); end
    tap(8);
    checks++; if (preview_char !== 8'h59) begin errors++; $display("FAIL wrap_prev3: got %h required 59", preview_char); end
    wait_valid();
    checks++; if (out_char !== 8'h59) begin errors++; $display("FAIL wrap_char: got %h required 59", out_char); end
    accept();
  endtask

  task automatic test_back_to_back();
    tap(0);
    checks++; if (preview_char !== 8'h41) begin errors++; $display("FAIL b2b_prev0: got %h required 41", preview_char); end
    err_seen = 0;
    unstable = 0;
    tap(1);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid: got %b required 1", out_valid); end
    checks++; if (out_char !== 8'h41) begin errors++; $display("FAIL b2b_char: got %h required 41", out_char); end
    checks++; if (preview_char !== 8'h44) begin errors++; $display("FAIL b2b_pend_prev: got %h required 44", preview_char); end
    tap(2);
    repeat (10) cyc();
    checks++; if (err_seen !== 1) begin errors++; $display("FAIL b2b_drop_err: pulses %0d required 1", err_seen); end
    checks++; if (unstable !== 0) begin errors++; $display("FAIL b2b_stable: changes %0d required 0", unstable); end
    checks++; if (out_char !== 8'h41 || out_valid !== 1'b1) begin errors++; $display("FAIL b2b_held: got %h/%b required 41/1", out_char, out_valid); end
    accept();
    checks++; if (preview_char !== 8'h44) begin errors++; $display("FAIL b2b_next_prev: got %h required 44", preview_char); end
    wait_valid();
    checks++; if (out_char !== 8'h44) begin errors++; $display("FAIL b2b_char2: got %h required 44", out_char); end
    accept();
  endtask

  task automatic test_clear();
    tap(4);
    tap(4);
    checks++; if (preview_char !== 8'h4E) begin errors++; $display("FAIL clear_prev: got %h required 4E", preview_char); end
    tap(14);
    checks++; if (preview_char !== 8'h20) begin errors++; $display("FAIL clear_discard: got %h required 20", preview_char); end
    repeat (60) cyc();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL clear_no_out: out_valid=%b required 0", out_valid); end
    tap(14);
    checks++; if (out_valid !== 1'b1 || out_char !== 8'h08) begin errors++; $display("FAIL clear_bksp: got %h/%b required 08/1", out_char, out_valid); end
    accept();
  endtask

  task automatic test_submit();
    tap(5);
    checks++; if (preview_char !== 8'h50) begin errors++; $display("FAIL submit_prev: got %h required 50", preview_char); end
    tap(15);
    checks++; if (out_valid !== 1'b1 || out_char !== 8'h50) begin errors++; $display("FAIL submit_commit: got %h/%b required 50/1", out_char, out_valid); end
    checks++; if (preview_char !== 8'h20) begin errors++; $display("FAIL submit_emit_prev: got %h required 20", preview_char); end
    accept();
    tap(15);
    checks++; if (out_valid !== 1'b1 || out_char !== 8'h0D) begin errors++; $display("FAIL submit_cr: got %h/%b required 0D/1", out_char, out_valid); end
    accept();
  endtask

  task automatic test_errors();
    err_seen = 0;
    press_raw(0, 4'b0011);
    checks++; if (err_seen !== 1) begin errors++; $display("FAIL multirow_err: pulses %0d required 1", err_seen); end
    checks++; if (out_valid !== 1'b0 || preview_char !== 8'h20) begin errors++; $display("FAIL multirow_quiet: got %b/%h required 0/20", out_valid, preview_char); end
    err_seen = 0;
    tap(9);
    checks++; if (err_seen !== 1) begin errors++; $display("FAIL unused_err: pulses %0d required 1", err_seen); end
    checks++; if (out_valid !== 1'b0 || preview_char !== 8'h20) begin errors++; $display("FAIL unused_quiet: got %b/%h required 0/20", out_valid, preview_char); end
  endtask

  task automatic test_reset_mid();
    tap(3);
    checks++; if (preview_char !== 8'h4A) begin errors++; $display("FAIL rstmid_prev: got %h required 4A", preview_char); end
    nRst = 1'b0;
    #1;
    checks++; if (col !== 4'b0001 || out_valid !== 1'b0 || error !== 1'b0) begin errors++; $display("FAIL rstmid_ctrl: col=%b valid=%b err=%b required 0001/0/0", col, out_valid, error); end
    checks++; if (out_char !== 8'h00 || preview_char !== 8'h20) begin errors++; $display("FAIL rstmid_chars: got %h/%h required 00/20", out_char, preview_char); end
    repeat (3) cyc();
    nRst = 1'b1;
    repeat (80) cyc();
    checks++; if (out_valid !== 1'b0 || preview_char !== 8'h20) begin errors++; $display("FAIL rstmid_stale: got %b/%h required 0/20", out_valid, preview_char); end
  endtask

  initial begin
    test_reset();
    test_multitap();
    test_wrap();
    test_back_to_back();
    test_clear();
    test_submit();
    test_errors();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
